// File: rtl/prog_counter_pkg.sv
// Shared definitions for the programmable counter: FSM state encoding and
// count-direction constants.
package prog_counter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/tick_prescaler.sv
// Enable-gated clock-enable divider: pulses tick once every div+1 enabled cycles.
// Only compiled when PRESCALE_EN is defined.
`ifdef PRESCALE_EN
module tick_prescaler #(
    parameter int PRESCALE_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  en,
    input  logic [PRESCALE_W-1:0] div,
    output logic                  tick
);

    logic [PRESCALE_W-1:0] phase;

    // >= rather than == so that lowering div mid-count cannot strand the phase
    assign tick = en && (phase >= div);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            phase <= '0;
        end else if (en) begin
            if (phase >= div) begin
                phase <= '0;
            end else begin
                phase <= phase + PRESCALE_W'(1);
            end
        end
    end

endmodule
`endif

// File: rtl/prog_counter.sv
// Programmable up/down counter with load, terminal-count pulse and IDLE/RUN/DONE
// control. Defining PRESCALE_EN adds a div input and an internal tick prescaler.
module prog_counter
    import prog_counter_pkg::*;
#(
    parameter int               WIDTH      = 32,
    parameter logic [WIDTH-1:0] RESET_VAL  = '0,
    parameter int               PRESCALE_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  load,
    input  logic [WIDTH-1:0]      load_val,
    input  logic [WIDTH-1:0]      limit,
    input  logic                  dir,
    input  logic                  one_shot,
    input  logic                  start,
`ifdef PRESCALE_EN
    input  logic [PRESCALE_W-1:0] div,
`endif
    output logic [WIDTH-1:0]      count,
    output logic                  tc,
    output logic                  running
);

    if (WIDTH < 2 || WIDTH > 32 || PRESCALE_W < 1) begin : g_param_check
        $error("prog_counter: unsupported WIDTH or PRESCALE_W");
    end

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] count_nxt;
    logic             tc_nxt;
    logic             tick;
    logic             terminal;
    logic [WIDTH-1:0] count_inc;
    logic [WIDTH-1:0] count_dec;
    logic [WIDTH-1:0] limit_m1;

`ifdef PRESCALE_EN
    tick_prescaler #(
        .PRESCALE_W(PRESCALE_W)
    ) u_prescaler (
        .clk  (clk),
        .reset(reset),
        .clear(load | start),
        .en   (en),
        .div  (div),
        .tick (tick)
    );
`else
    assign tick = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            count <= RESET_VAL;
            tc    <= 1'b0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
            tc    <= tc_nxt;
        end
    end

    // Load beats everything; otherwise only RUN with en and tick advances the count
    always_comb begin
        state_nxt = state;
        count_nxt = count;
        tc_nxt    = 1'b0;
        terminal  = 1'b0;
        count_inc = count + WIDTH'(1);
        count_dec = count - WIDTH'(1);
        limit_m1  = limit - WIDTH'(1);

        if (load) begin
            count_nxt = load_val;
            state_nxt = ST_RUN;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_nxt = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (en && tick) begin
                        case (dir)
                            DIR_UP: begin
                                if (count_inc == limit) begin
                                    count_nxt = '0;
                                    terminal  = 1'b1;
                                end else begin
                                    count_nxt = count_inc;
                                end
                            end
                            DIR_DOWN: begin
                                if (count == '0) begin
                                    count_nxt = limit_m1;
                                    terminal  = 1'b1;
                                end else begin
                                    count_nxt = count_dec;
                                end
                            end
                            default: count_nxt = count;
                        endcase
                        tc_nxt = terminal;
                        if (terminal && one_shot) begin
                            state_nxt = ST_DONE;
                        end
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    assign running = (state == ST_RUN);

endmodule

// File: tb/tb_prog_counter.sv
// Scoreboard bench for prog_counter (WIDTH=4, RESET_VAL=5): a driver pushes the
// model's expected outputs, a monitor pops and compares after each rising edge.
module tb_prog_counter;

    localparam int W   = 4;
    localparam int MOD = 1 << W;
    localparam int RV  = 5;

    logic         clk = 1'b0;
    logic         reset;
    logic         en;
    logic         load;
    logic [W-1:0] load_val;
    logic [W-1:0] limit;
    logic         dir;
    logic         one_shot;
    logic         start;
    logic [W-1:0] count;
    logic         tc;
    logic         running;
`ifdef PRESCALE_EN
    logic [7:0]   div = 8'd0;
`endif

    typedef struct {
        int count;
        bit tc;
        bit running;
    } exp_t;

    exp_t exp_q[$];
    int   tests_run    = 0;
    int   tests_failed = 0;
    int   cycle_no     = 0;

    // Reference model state: value, pulse, and whether the counter is armed
    int m_count;
    bit m_tc;
    bit m_run;

    prog_counter #(
        .WIDTH     (W),
        .RESET_VAL (W'(RV)),
        .PRESCALE_W(8)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .load    (load),
        .load_val(load_val),
        .limit   (limit),
        .dir     (dir),
        .one_shot(one_shot),
        .start   (start),
`ifdef PRESCALE_EN
        .div     (div),
`endif
        .count   (count),
        .tc      (tc),
        .running (running)
    );

    always #5 clk = ~clk;

    task automatic model_update();
        int lim;
        lim = int'(limit);
        if (reset) begin
            m_count = RV;
            m_tc    = 0;
            m_run   = 0;
        end else if (load) begin
            m_count = int'(load_val);
            m_tc    = 0;
            m_run   = 1;
        end else if (!m_run) begin
            m_tc = 0;
            if (start) m_run = 1;
        end else if (!en) begin
            m_tc = 0;
        end else begin
            if (dir == 1'b0) begin
                if ((m_count + 1) % MOD == lim) begin
                    m_count = 0;
                    m_tc    = 1;
                end else begin
                    m_count = (m_count + 1) % MOD;
                    m_tc    = 0;
                end
            end else begin
                if (m_count == 0) begin
                    m_count = (lim + MOD - 1) % MOD;
                    m_tc    = 1;
                end else begin
                    m_count = m_count - 1;
                    m_tc    = 0;
                end
            end
            if (m_tc && one_shot) m_run = 0;
        end
    endtask

    task automatic apply_stimulus(input bit r, input bit e, input bit l,
                                  input logic [W-1:0] lv, input logic [W-1:0] lim,
                                  input bit d, input bit os, input bit s);
        exp_t ex;
        reset    = r;
        en       = e;
        load     = l;
        load_val = lv;
        limit    = lim;
        dir      = d;
        one_shot = os;
        start    = s;
        model_update();
        ex.count   = m_count;
        ex.tc      = m_tc;
        ex.running = m_run;
        exp_q.push_back(ex);
        @(negedge clk);
    endtask

    task automatic check_output(input exp_t ex);
        tests_run++;
        if (int'(count) != ex.count || tc !== ex.tc || running !== ex.running) begin
            tests_failed++;
            $display("[TB] FAIL cycle %0d: got count=%0d tc=%0b running=%0b, expected count=%0d tc=%0b running=%0b",
                     cycle_no, count, tc, running, ex.count, ex.tc, ex.running);
        end
    endtask

    initial begin : monitor
        exp_t ex;
        forever begin
            @(posedge clk);
            #1;
            cycle_no++;
            if (exp_q.size() > 0) begin
                ex = exp_q.pop_front();
                check_output(ex);
            end
        end
    end

    initial begin : driver
        m_count = RV;
        m_tc    = 0;
        m_run   = 0;

        apply_stimulus(1, 0, 0, 4'd0, 4'd4, 0, 0, 0);
        apply_stimulus(1, 0, 0, 4'd0, 4'd4, 0, 0, 0);

        // Up-count wrap at limit 4 from a load of 0
        apply_stimulus(0, 1, 1, 4'd0, 4'd4, 0, 0, 0);
        for (int i = 0; i < 10; i++) apply_stimulus(0, 1, 0, 4'd0, 4'd4, 0, 0, 0);

        // Reset mid-run returns to RESET_VAL and IDLE
        apply_stimulus(1, 1, 0, 4'd0, 4'd4, 0, 0, 0);
        apply_stimulus(0, 1, 0, 4'd0, 4'd4, 0, 0, 0);

        // Down count one-shot from 0 with limit 3, then re-arm with start
        apply_stimulus(0, 1, 1, 4'd0, 4'd3, 1, 1, 0);
        apply_stimulus(0, 1, 0, 4'd0, 4'd3, 1, 1, 0);
        for (int i = 0; i < 5; i++) apply_stimulus(0, 1, 0, 4'd0, 4'd3, 1, 1, 0);
        apply_stimulus(0, 1, 0, 4'd0, 4'd3, 1, 1, 1);
        for (int i = 0; i < 4; i++) apply_stimulus(0, 1, 0, 4'd0, 4'd3, 1, 1, 0);

        // Load collides with a terminal step
        apply_stimulus(0, 1, 1, 4'd3, 4'd4, 0, 0, 0);
        apply_stimulus(0, 1, 1, 4'd7, 4'd4, 0, 0, 0);
        apply_stimulus(0, 1, 0, 4'd0, 4'd4, 0, 0, 0);

        // Enable gating across the full-range wrap with limit 0
        apply_stimulus(0, 0, 1, 4'd14, 4'd0, 0, 0, 0);
        apply_stimulus(0, 1, 0, 4'd0, 4'd0, 0, 0, 0);
        apply_stimulus(0, 0, 0, 4'd0, 4'd0, 0, 0, 0);
        apply_stimulus(0, 0, 0, 4'd0, 4'd0, 0, 0, 0);
        apply_stimulus(0, 1, 0, 4'd0, 4'd0, 0, 0, 0);

        // Start while running is ignored
        apply_stimulus(0, 1, 0, 4'd0, 4'd0, 0, 0, 1);

        // Randomized traffic with sticky direction, limit and mode
        begin
            bit           r_dir = 0;
            bit           r_os  = 0;
            logic [W-1:0] r_lim = 4'd6;
            for (int i = 0; i < 600; i++) begin
                if ($urandom_range(0, 15) == 0) r_dir = ~r_dir;
                if ($urandom_range(0, 19) == 0) r_os = ~r_os;
                if ($urandom_range(0, 11) == 0) r_lim = W'($urandom_range(0, MOD - 1));
                apply_stimulus($urandom_range(0, 79) == 0,
                               $urandom_range(0, 3) != 0,
                               $urandom_range(0, 11) == 0,
                               W'($urandom_range(0, MOD - 1)),
                               r_lim, r_dir, r_os,
                               $urandom_range(0, 7) == 0);
            end
        end

        apply_stimulus(0, 0, 0, 4'd0, 4'd0, 0, 0, 0);
        @(posedge clk);
        @(posedge clk);
        #2;
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("[TB] FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
